// File: rtl/fta_bus_pkg.sv
// fta_bus_pkg: shared FTA bus command codes, transaction-id width and the
// arbiter state encoding used by wb_fta_arbiter.
package fta_bus_pkg;

  // Width of the FTA transaction id carried on request and response.
  localparam int unsigned TidW = 4;

  typedef enum logic [3:0] {
    CMD_LOAD  = 4'h0,
    CMD_STORE = 4'h1
  } fta_cmd_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fta_bus_interface.sv
// fta_bus_interface: single-outstanding FTA request/response bus.
// The master drives req and samples resp; the slave does the opposite.
interface fta_bus_interface
  import fta_bus_pkg::*;
#(
  parameter int unsigned WID = 256
);

  typedef struct packed {
    logic                 cyc;
    logic                 we;
    fta_cmd_t             cmd;
    logic [WID/8-1:0]     sel;
    logic [31:0]          adr;
    logic [WID-1:0]       data1;
    logic [TidW-1:0]      tid;
  } fta_req_t;

  typedef struct packed {
    logic                 ack;
    logic [TidW-1:0]      tid;
    logic [WID-1:0]       dat;
  } fta_resp_t;

  fta_req_t  req;
  fta_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);

endinterface

// File: rtl/fta_rr_picker.sv
// fta_rr_picker: combinational round-robin selector. Searches upward from
// last_i + 1 (modulo NREQ) and returns the first asserted request.
module fta_rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] last_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  // One extra bit so last_i + k never overflows before the modulo wrap.
  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand_idx;

  // Walk candidates in priority order; the first hit wins.
  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    sum      = '0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      sum = {1'b0, last_i} + (IdxW + 1)'(k);
      if (sum >= (IdxW + 1)'(NREQ)) begin
        sum = sum - (IdxW + 1)'(NREQ);
      end
      cand_idx = sum[IdxW-1:0];
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/wb_fta_arbiter.sv
// wb_fta_arbiter: round-robin arbiter from NREQ Wishbone requesters onto one
// FTA master port, one transaction outstanding at a time.
// Optional response timeout: define WB_FTA_ARB_TIMEOUT_EN to enable err_o.
module wb_fta_arbiter
  import fta_bus_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WID   = 256,
  parameter int unsigned TOVAL = 1023
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NREQ-1:0]                  cyc_i,
  input  logic [NREQ-1:0]                  stb_i,
  input  logic [NREQ-1:0]                  we_i,
  input  logic [NREQ-1:0][WID/8-1:0]       sel_i,
  input  logic [NREQ-1:0][31:0]            adr_i,
  input  logic [NREQ-1:0][WID-1:0]         dat_i,
  output logic [NREQ-1:0]                  ack_o,
  output logic [NREQ-1:0]                  err_o,
  output logic [WID-1:0]                   dat_o,
  fta_bus_interface.master                 fta_o
);

  localparam int unsigned IdxW = $clog2(NREQ);

  logic [NREQ-1:0] elig;
  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;

  arb_state_t      state_q;
  logic [IdxW-1:0] grant_q;
  logic [IdxW-1:0] last_q;
  logic [TidW-1:0] tid_cnt_q;
  logic [TidW-1:0] tid_q;
  logic            abandon_q;
  logic [NREQ-1:0] ack_q;
  logic [WID-1:0]  dat_q;

  logic            resp_hit;
  logic            drop;

`ifdef WB_FTA_ARB_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TOVAL + 1);
  logic [NREQ-1:0] err_q;
  logic [ToW-1:0]  to_cnt_q;
`else
  // The timeout value only matters in the timeout-enabled build.
  logic unused_toval;
  assign unused_toval = ^TOVAL;
`endif

  // A requester competes only while it holds both cyc and stb.
  assign elig = cyc_i & stb_i;

  fta_rr_picker #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_picker (
    .req_i   (elig),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Only a response carrying the tid we issued belongs to us.
  assign resp_hit = fta_o.resp.ack && (fta_o.resp.tid == tid_q);
  // Requester gave up its cycle: any result must be swallowed.
  assign drop     = abandon_q | ~cyc_i[grant_q];

  // Arbiter FSM with registered request and Wishbone outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      last_q    <= IdxW'(NREQ - 1);
      tid_cnt_q <= '0;
      tid_q     <= '0;
      abandon_q <= 1'b0;
      ack_q     <= '0;
      dat_q     <= '0;
      fta_o.req <= '0;
`ifdef WB_FTA_ARB_TIMEOUT_EN
      err_q     <= '0;
      to_cnt_q  <= '0;
`endif
    end else begin
      // The request is a single-cycle pulse; zero unless issuing below.
      fta_o.req <= '0;
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_q         <= pick_idx;
            fta_o.req.cyc   <= 1'b1;
            fta_o.req.we    <= we_i[pick_idx];
            fta_o.req.cmd   <= we_i[pick_idx] ? CMD_STORE : CMD_LOAD;
            fta_o.req.sel   <= sel_i[pick_idx];
            fta_o.req.adr   <= adr_i[pick_idx];
            fta_o.req.data1 <= dat_i[pick_idx];
            fta_o.req.tid   <= tid_cnt_q;
            tid_q           <= tid_cnt_q;
            tid_cnt_q       <= tid_cnt_q + TidW'(1);
            abandon_q       <= 1'b0;
`ifdef WB_FTA_ARB_TIMEOUT_EN
            to_cnt_q        <= '0;
`endif
            state_q         <= StWait;
          end
        end
        StWait: begin
          if (!cyc_i[grant_q]) begin
            abandon_q <= 1'b1;
          end
          // A matching response takes priority over a timeout in the same cycle.
          if (resp_hit) begin
            if (drop) begin
              last_q  <= grant_q;
              state_q <= StIdle;
            end else begin
              ack_q[grant_q] <= 1'b1;
              dat_q          <= fta_o.resp.dat;
              state_q        <= StDone;
            end
          end
`ifdef WB_FTA_ARB_TIMEOUT_EN
          else if (to_cnt_q == ToW'(TOVAL)) begin
            if (drop) begin
              last_q  <= grant_q;
              state_q <= StIdle;
            end else begin
              err_q[grant_q] <= 1'b1;
              state_q        <= StDone;
            end
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
          end
`endif
        end
        StDone: begin
          // Hold the result until the requester ends its bus cycle.
          if (!cyc_i[grant_q]) begin
            ack_q   <= '0;
            dat_q   <= '0;
`ifdef WB_FTA_ARB_TIMEOUT_EN
            err_q   <= '0;
`endif
            last_q  <= grant_q;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;
`ifdef WB_FTA_ARB_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = '0;
`endif

endmodule

// File: tb/tb_wb_fta_arbiter.sv
// tb_wb_fta_arbiter: randomized self-checking bench for wb_fta_arbiter.
// Honours WB_FTA_ARB_TIMEOUT_EN the same way the design does.
module tb_wb_fta_arbiter;
  import fta_bus_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int          NR    = 4;
  localparam int unsigned WID   = 64;
  localparam int unsigned SELW  = WID / 8;
  localparam int unsigned TOVAL = 15;
  localparam int unsigned GW    = 2;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic [NREQ-1:0]            cyc_i;
  logic [NREQ-1:0]            stb_i;
  logic [NREQ-1:0]            we_i;
  logic [NREQ-1:0][SELW-1:0]  sel_i;
  logic [NREQ-1:0][31:0]      adr_i;
  logic [NREQ-1:0][WID-1:0]   dat_i;
  logic [NREQ-1:0]            ack_o;
  logic [NREQ-1:0]            err_o;
  logic [WID-1:0]             dat_o;

  fta_bus_interface #(.WID(WID)) fta ();

  wb_fta_arbiter #(
    .NREQ  (NREQ),
    .WID   (WID),
    .TOVAL (TOVAL)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .cyc_i (cyc_i),
    .stb_i (stb_i),
    .we_i  (we_i),
    .sel_i (sel_i),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .ack_o (ack_o),
    .err_o (err_o),
    .dat_o (dat_o),
    .fta_o (fta)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  // Reference model state: who was served last and the next tid to be issued.
  int m_last;
  int m_tid;

  task automatic check_eq(input string tag, input logic [WID-1:0] got,
                          input logic [WID-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; check global invariants.
  task automatic step();
    @(posedge clk_i);
    #1;
    check_eq("ack_err_at_most_one", WID'($countones(ack_o | err_o) <= 1), WID'(1));
    if (ack_o == '0) check_eq("dat_zero_without_ack", dat_o, '0);
  endtask

  // Eligible requester nearest above the last grant, by circular distance.
  function automatic logic [GW-1:0] exp_grant(input logic [NREQ-1:0] elig, input int last);
    int best;
    int bestd;
    int d;
    logic [GW-1:0] ni;
    best  = 0;
    bestd = NR;
    for (int n = 0; n < NR; n++) begin
      ni = GW'(n);
      d  = (n - last - 1 + 2 * NR) % NR;
      if (elig[ni] && d < bestd) begin
        best  = n;
        bestd = d;
      end
    end
    return GW'(best);
  endfunction

  task automatic rand_fields();
    for (int n = 0; n < NR; n++) begin
      we_i[n]  = 1'($urandom);
      sel_i[n] = SELW'($urandom);
      adr_i[n] = ($urandom & 32'hFFFF_FFF0) | 32'(n);
      dat_i[n] = {$urandom, $urandom};
    end
  endtask

  // Check the request pulse that follows a grant edge.
  task automatic expect_issue(input logic [GW-1:0] g);
    check_eq("issue_cyc", WID'(fta.req.cyc), WID'(1));
    check_eq("issue_tid", WID'(fta.req.tid), WID'(m_tid));
    check_eq("issue_adr", WID'(fta.req.adr), WID'(adr_i[g]));
    check_eq("issue_we", WID'(fta.req.we), WID'(we_i[g]));
    check_eq("issue_cmd", WID'(fta.req.cmd), we_i[g] ? WID'(CMD_STORE) : WID'(CMD_LOAD));
    check_eq("issue_sel", WID'(fta.req.sel), WID'(sel_i[g]));
    check_eq("issue_data1", fta.req.data1, dat_i[g]);
    check_eq("issue_no_ack", WID'(ack_o), '0);
  endtask

  // Respond after lat quiet cycles (optionally preceded by a wrong-tid ack),
  // hold the result for hold cycles, then end the requester's cycle.
  task automatic complete(input logic [GW-1:0] g, input int lat, input bit stale,
                          input logic [WID-1:0] rdat, input int hold);
    logic [NREQ-1:0] oh;
    oh    = '0;
    oh[g] = 1'b1;
    step();
    check_eq("req_one_cycle", WID'(fta.req.cyc), '0);
    for (int i = 0; i < lat; i++) begin
      step();
      check_eq("no_early_ack", WID'(ack_o), '0);
      check_eq("no_err", WID'(err_o), '0);
      check_eq("no_extra_req", WID'(fta.req.cyc), '0);
    end
    if (stale) begin
      fta.resp.ack = 1'b1;
      fta.resp.tid = TidW'(m_tid + 1);
      fta.resp.dat = ~rdat;
      step();
      fta.resp = '0;
      check_eq("stale_tid_ignored", WID'(ack_o), '0);
      step();
      check_eq("stale_tid_ignored_2", WID'(ack_o), '0);
    end
    fta.resp.ack = 1'b1;
    fta.resp.tid = TidW'(m_tid);
    fta.resp.dat = rdat;
    step();
    fta.resp = '0;
    check_eq("ack_vec", WID'(ack_o), WID'(oh));
    check_eq("ack_dat", dat_o, rdat);
    check_eq("ack_no_err", WID'(err_o), '0);
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq("ack_held", WID'(ack_o), WID'(oh));
      check_eq("dat_held", dat_o, rdat);
    end
    cyc_i[g] = 1'b0;
    stb_i[g] = 1'b0;
    step();
    check_eq("ack_cleared", WID'(ack_o), '0);
    check_eq("dat_cleared", dat_o, '0);
    check_eq("no_grant_on_release_edge", WID'(fta.req.cyc), '0);
    m_last = int'(g);
    m_tid  = (m_tid + 1) % 16;
  endtask

  task automatic round(input logic [NREQ-1:0] cm, input logic [NREQ-1:0] sm, input int lat,
                       input bit stale, input logic [WID-1:0] rdat, input int hold);
    logic [GW-1:0] g;
    cyc_i = cm;
    stb_i = sm;
    g     = exp_grant(cm & sm, m_last);
    step();
    expect_issue(g);
    complete(g, lat, stale, rdat, hold);
  endtask

  initial begin
    int order [5];
    logic [NREQ-1:0] cm;
    logic [NREQ-1:0] sm;
    logic [GW-1:0]   ri;
    logic [TidW-1:0] old_tid;

    order  = '{0, 1, 2, 3, 0};
    rst_i  = 1'b1;
    cyc_i  = '0;
    stb_i  = '0;
    we_i   = '0;
    sel_i  = '0;
    adr_i  = '0;
    dat_i  = '0;
    fta.resp = '0;
    m_last = NR - 1;
    m_tid  = 0;
    step();
    step();
    check_eq("reset_ack", WID'(ack_o), '0);
    check_eq("reset_err", WID'(err_o), '0);
    check_eq("reset_dat", dat_o, '0);
    check_eq("reset_req", WID'(|fta.req), '0);
    rst_i = 1'b0;

    // All requesters hold requests continuously: strict rotation from 0.
    for (int r = 0; r < 5; r++) begin
      rand_fields();
      cyc_i = '1;
      stb_i = '1;
      step();
      expect_issue(GW'(order[r]));
      complete(GW'(order[r]), 1, 1'b0, {$urandom, $urandom}, 0);
    end

    // Single load from requester 0.
    rand_fields();
    we_i[0]  = 1'b0;
    adr_i[0] = 32'h0000_1000;
    round(4'b0001, 4'b0001, 2, 1'b0, {8{8'hA5}}, 1);

    // Wrong-tid ack followed two clocks later by the right one.
    rand_fields();
    round(4'b0110, 4'b0110, 1, 1'b1, {$urandom, $urandom}, 0);

    // Randomized traffic, including requesters with cyc but no stb.
    for (int r = 0; r < 40; r++) begin
      rand_fields();
      cm = NREQ'($urandom);
      sm = NREQ'($urandom);
      if ((cm & sm) == '0) begin
        ri     = GW'($urandom);
        cm[ri] = 1'b1;
        sm[ri] = 1'b1;
      end
      round(cm, sm, int'($urandom_range(0, 4)), ($urandom % 4) == 0,
            {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    // Response never arrives for requester 3.
    rand_fields();
    cyc_i = 4'b1000;
    stb_i = 4'b1000;
    step();
    expect_issue(2'd3);
`ifdef WB_FTA_ARB_TIMEOUT_EN
    repeat (15) step();
    check_eq("err_not_early", WID'(err_o), '0);
    step();
    check_eq("timeout_err", WID'(err_o), WID'(4'b1000));
    check_eq("timeout_no_ack", WID'(ack_o), '0);
    check_eq("timeout_dat_zero", dat_o, '0);
    step();
    check_eq("timeout_err_held", WID'(err_o), WID'(4'b1000));
    cyc_i[3] = 1'b0;
    stb_i[3] = 1'b0;
    step();
    check_eq("timeout_err_cleared", WID'(err_o), '0);
    m_last = 3;
    m_tid  = (m_tid + 1) % 16;
`else
    // Without the timeout the arbiter just keeps waiting.
    complete(2'd3, 99, 1'b0, {$urandom, $urandom}, 0);
`endif

    // Requester 1 abandons its cycle while the response is pending.
    rand_fields();
    cyc_i = 4'b0010;
    stb_i = 4'b0010;
    step();
    expect_issue(2'd1);
    step();
    cyc_i[1] = 1'b0;
    stb_i[1] = 1'b0;
    step();
    step();
    fta.resp.ack = 1'b1;
    fta.resp.tid = TidW'(m_tid);
    fta.resp.dat = {$urandom, $urandom};
    step();
    fta.resp = '0;
    check_eq("abandon_no_ack", WID'(ack_o), '0);
    check_eq("abandon_no_err", WID'(err_o), '0);
    step();
    check_eq("abandon_still_no_ack", WID'(ack_o), '0);
    check_eq("abandon_no_req", WID'(fta.req.cyc), '0);
    m_tid = (m_tid + 1) % 16;

    // Reset while requester 2 waits; the late response must be ignored.
    rand_fields();
    cyc_i = 4'b0100;
    stb_i = 4'b0100;
    step();
    expect_issue(2'd2);
    old_tid = TidW'(m_tid);
    step();
    rst_i = 1'b1;
    step();
    check_eq("midreset_ack", WID'(ack_o), '0);
    check_eq("midreset_err", WID'(err_o), '0);
    check_eq("midreset_dat", dat_o, '0);
    check_eq("midreset_req", WID'(|fta.req), '0);
    rst_i  = 1'b0;
    m_tid  = 0;
    m_last = NR - 1;
    fta.resp.ack = 1'b1;
    fta.resp.tid = old_tid;
    fta.resp.dat = {$urandom, $urandom};
    step();
    fta.resp = '0;
    expect_issue(2'd2);
    complete(2'd2, 1, 1'b0, {$urandom, $urandom}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_fta_arbiter.md
WB_FTA_ARBITER -- requirements
Module: wb_fta_arbiter

Interface
REQ-001 Parameters SHALL be:
- NREQ, 4, number of Wishbone requesters (2..8)
- WID, 256, data width
- TOVAL, 1023, response timeout in clocks
REQ-002 Ports SHALL be:
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  synchronous active-high reset
- cyc_i  input  NREQ  per-requester bus cycle
- stb_i  input  NREQ  per-requester strobe
- we_i  input  NREQ  per-requester write enable
- sel_i  input  NREQ x WID/8  byte selects
- adr_i  input  NREQ x 32  addresses
- dat_i  input  NREQ x WID  write data
- ack_o  output  NREQ  per-requester acknowledge
- err_o  output  NREQ  per-requester error (timeout)
- dat_o  output  WID  read data, shared, valid with ack_o
- fta_o  fta_bus_interface.master  --  single shared FTA master port

Function
REQ-003 FSM SHALL have states IDLE, WAIT, DONE; one outstanding transaction.
REQ-004 In IDLE, a requester is eligible when cyc_i[n]&stb_i[n]; grant SHALL be round-robin, searching upward from last_grant+1 modulo NREQ.
REQ-005 On the edge a grant is made: register grant index, drive fta_o.req for exactly the next cycle with cyc=1, we=we_i[g], cmd=CMD_STORE if we else CMD_LOAD, sel, adr, data1 from requester g, tid=4-bit issue counter; enter WAIT; increment issue counter (wraps 15->0).
REQ-006 fta_o.req SHALL be all-zero in every cycle other than the issue cycle.
REQ-007 In WAIT, response accepted only when fta_o.resp.ack=1 and resp.tid equals issued tid; non-matching acks SHALL be ignored.
REQ-008 On accepted response: dat_o<=resp.dat, ack_o[g]<=1 (one clock after resp.ack), go DONE; latency request-to-ack = FTA latency + 2 clocks.
REQ-009 In DONE, ack_o[g]/err_o[g] and dat_o SHALL hold until cyc_i[g]=0; then clear ack_o, err_o, dat_o to 0, set last_grant=g, go IDLE. Next grant no earlier than the following edge.
REQ-010 If cyc_i[g] drops during WAIT, set abandon flag; on response or timeout SHALL discard it, assert nothing, go IDLE.
REQ-011 At most one bit of ack_o|err_o SHALL be high in any cycle; dat_o=0 whenever no ack_o bit is high.
REQ-012 Simultaneous accepted response and timeout expiry in same cycle: response wins.

Reset
REQ-013 rst_i SHALL force: state IDLE, ack_o=0, err_o=0, dat_o=0, fta_o.req=0, last_grant=NREQ-1, issue counter=0, abandon=0, timeout counter=0; reset mid-transaction abandons it silently; late responses after reset are ignored by tid/state.

Configuration
REQ-014 Macro WB_FTA_ARB_TIMEOUT_EN defined: WAIT counter counts clocks from issue; at TOVAL without response, err_o[g]<=1, go DONE (dat_o=0). Undefined: no counter, WAIT indefinitely, err_o tied 0.

Structure
REQ-015 State enum (arb_state_t) and the 4-bit tid width constant SHALL live in fta_bus_pkg; CMD_LOAD/CMD_STORE reused from fta_bus_pkg.
REQ-016 Round-robin selection SHALL be one sub-module, fta_rr_picker (inputs req vector, last grant; outputs valid, index), combinational.

Verification
REQ-017 Single load: req0 read adr 0x1000, FTA model acks after 3 clks with dat=0xA5.. -> fta_o.req.cmd=CMD_LOAD one cycle, ack_o[0]=1 with dat_o=0xA5.., cleared after cyc_i[0] drop.
REQ-018 Fairness: all 4 requesters hold continuous requests, last_grant=3 after reset -> grant order 0,1,2,3,0; each exactly one fta_o.req pulse.
REQ-019 Stale tid: model returns ack with tid=issued+1, then correct tid 2 clks later -> only second produces ack_o; dat_o from second.
REQ-020 Timeout (macro on, TOVAL=15): no response -> err_o[g]=1 at issue+16 clks, ack_o stays 0; macro off -> no err_o after 100 clks.
REQ-021 Abandon/reset: req1 drops cyc in WAIT, response arrives -> no ack_o; separately rst_i asserted in WAIT -> all outputs 0 next cycle, later response ignored, req2 then served normally.
